md_tim_wr_capture: RTL

//  Capture block that feeds the mapper control registers. Samples the async MD bus

---
 rtl/md_tim_wr_capture.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/md_tim_wr_capture.sv
// rtl/md_tim_wr_capture.sv - MD bus write capture: strobe sync, glitch filter, A130xx window qualify, FWFT write queue
module md_tim_wr_capture #(
    parameter int          FILTER_LEN = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] ADDR_BASE  = 16'hA130
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:1] i_md_a,
    input  logic [15:0] i_md_d,
    input  logic        i_md_asn,
    input  logic        i_md_weln,
    input  logic        i_md_wehn,
    output logic        o_wr_valid,
    input  logic        i_wr_ready,
    output logic [6:0]  o_wr_addr,
    output logic [15:0] o_wr_data,
    output logic [1:0]  o_wr_be,
    output logic        o_ovf,
    input  logic        i_ovf_clr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 25;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_WAIT_REL} state_t;

    logic [1:0]  r_asn_s, r_weln_s, r_wehn_s;
    logic [23:1] r_a_s1, r_a_s2;
    logic [15:0] r_d_s1, r_d_s2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_asn_s  <= 2'b11;
            r_weln_s <= 2'b11;
            r_wehn_s <= 2'b11;
            r_a_s1   <= '0;
            r_a_s2   <= '0;
            r_d_s1   <= '0;
            r_d_s2   <= '0;
        end else begin
            r_asn_s  <= {r_asn_s[0], i_md_asn};
            r_weln_s <= {r_weln_s[0], i_md_weln};
            r_wehn_s <= {r_wehn_s[0], i_md_wehn};
            r_a_s1   <= i_md_a;
            r_a_s2   <= r_a_s1;
            r_d_s1   <= i_md_d;
            r_d_s2   <= r_d_s1;
        end
    end

    logic w_act;
    assign w_act = !r_asn_s[1] && (!r_weln_s[1] || !r_wehn_s[1]) && (r_a_s2[23:8] == ADDR_BASE);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_prime;
    logic       w_push;

    // Push fires on the edge the filter count completes, so the FIFO captures the same edge.
    assign w_push = w_act && (((r_state == S_IDLE) && (FILTER_LEN == 1)) ||
                              ((r_state == S_COUNT) && (r_cnt == 4'(FILTER_LEN - 1))));

    // r_prime keeps WAIT_REL from trusting the sync flops' reset values, so a strobe
    // held through reset release is only seen once it has truly propagated.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_WAIT_REL;
            r_cnt   <= '0;
            r_prime <= '0;
        end else begin
            r_prime <= {r_prime[0], 1'b1};
            case (r_state)
                S_IDLE: begin
                    if (w_act) begin
                        if (FILTER_LEN == 1) begin
                            r_state <= S_WAIT_REL;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_COUNT;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                S_COUNT: begin
                    if (!w_act) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == 4'(FILTER_LEN - 1)) begin
                        r_state <= S_WAIT_REL;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_WAIT_REL: begin
                    if (r_prime[1] && !w_act) r_state <= S_IDLE;
                end
                default: r_state <= S_WAIT_REL;
            endcase
        end
    end

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          w_full, w_empty, w_pop, w_wr, w_drop;
    logic [EW-1:0] w_entry;

    assign w_entry = {~r_wehn_s[1], ~r_weln_s[1], r_a_s2[7:1], r_d_s2};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = !w_empty && i_wr_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= w_entry;
                r_wp        <= r_wp + PW'(1);
            end
            if (w_pop) r_rp <= r_rp + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)         r_ovf <= 1'b1;
            else if (i_ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign o_wr_valid = !w_empty;
    assign {o_wr_be, o_wr_addr, o_wr_data} = r_mem[r_rp];
    assign o_ovf = r_ovf;
endmodule
